uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 106 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte requesters, the arbiter and uart_byte_tx.
// The arbiter uses the slave modport; the requester/UART side uses master.
interface uart_tx_arbiter_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0]   req;
  logic [8*N-1:0] data_in;
  logic           Tx_Done;
  logic           uart_state;
  logic           send_en;
  logic [7:0]     data_byte;
  logic [N-1:0]   ack;
  logic [2:0]     grant_id;
  logic           busy;
  logic           timeout_err;

  modport slave (
    input  req, data_in, Tx_Done, uart_state,
    output send_en, data_byte, ack, grant_id, busy, timeout_err
  );

  modport master (
    output req, data_in, Tx_Done, uart_state,
    input  send_en, data_byte, ack, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_byte_tx between N byte requesters,
// with a watchdog that abandons a transfer whose Tx_Done never arrives.
module uart_tx_arbiter #(
  parameter int unsigned N       = 4,
  parameter logic [31:0] TIMEOUT = 32'd200000,
  parameter int unsigned CW      = 18
) (
  input logic              Clk,
  input logic              Rst,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

  localparam logic [CW-1:0] WdLast = CW'(TIMEOUT - 32'd1);

  state_e        state_q;
  logic [2:0]    last_q;
  logic [2:0]    grant_q;
  logic [7:0]    data_q;
  logic [N-1:0]  ack_q;
  logic          send_en_q;
  logic          busy_q;
  logic          tout_q;
  logic [CW-1:0] wd_q;

  logic [N-1:0]  req_eff;
  logic          pick_found;
  logic [2:0]    pick_idx;
  logic [7:0]    pick_byte;

  // A requester still sees its own ack this cycle and may not have dropped req yet.
  assign req_eff = bus.req & ~ack_q;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_byte  = '0;
    for (int k = 1; k <= int'(N); k++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!pick_found && req_eff[i] && ((int'(last_q) + k) % int'(N) == i)) begin
          pick_found = 1'b1;
          pick_idx   = 3'(i);
          pick_byte  = bus.data_in[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= StIdle;
      last_q    <= 3'(N - 1);
      grant_q   <= '0;
      data_q    <= '0;
      ack_q     <= '0;
      send_en_q <= 1'b0;
      busy_q    <= 1'b0;
      tout_q    <= 1'b0;
      wd_q      <= '0;
    end else begin
      send_en_q <= 1'b0;
      ack_q     <= '0;
      tout_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_found && !bus.uart_state) begin
            data_q  <= pick_byte;
            grant_q <= pick_idx;
            busy_q  <= 1'b1;
            state_q <= StSend;
          end
        end
        StSend: begin
          send_en_q <= 1'b1;
          wd_q      <= '0;
          state_q   <= StWait;
        end
        StWait: begin
          wd_q <= wd_q + CW'(1);
          // Tx_Done takes precedence over a simultaneous watchdog expiry.
          if (bus.Tx_Done) begin
            ack_q   <= N'(1) << grant_q;
            last_q  <= grant_q;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (wd_q == WdLast) begin
            tout_q  <= 1'b1;
            last_q  <= grant_q;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.send_en     = send_en_q;
  assign bus.data_byte   = data_q;
  assign bus.ack         = ack_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected grants, acks and
// timeouts; a monitor pops and compares whenever the DUT presents one.
module tb_uart_tx_arbiter;
  localparam int unsigned N       = 4;
  localparam logic [31:0] TIMEOUT = 32'd50;
  localparam int unsigned CW      = 8;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] b;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N(N)) bus ();

  uart_tx_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int td_delay    = -1;
  int gen         = 0;

  xfer_t      exp_send[$];
  logic [3:0] exp_ack[$];
  logic [2:0] exp_tout[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_send(input int lim);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.send_en && c < lim);
    if (!bus.send_en) fail_now("send_en wait expired", 32'(c));
  endtask

  task automatic wait_idle(input int lim);
    int c = 0;
    while (bus.busy && c < lim) begin
      @(negedge clk);
      c++;
    end
    if (bus.busy) fail_now("busy wait expired", 32'(c));
  endtask

  task automatic push_send(input logic [2:0] id, input logic [7:0] b);
    xfer_t x;
    x.id = id;
    x.b  = b;
    exp_send.push_back(x);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " send_en"}, bus.send_en, 0);
    check({tag, " data_byte"}, bus.data_byte, 0);
    check({tag, " ack"}, bus.ack, 0);
    check({tag, " grant_id"}, bus.grant_id, 0);
    check({tag, " busy"}, bus.busy, 0);
    check({tag, " timeout_err"}, bus.timeout_err, 0);
  endtask

  // UART model: returns Tx_Done td_delay cycles after each send_en; a reset cancels it.
  initial begin : uart_model
    bus.Tx_Done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.send_en && td_delay >= 0) begin
        fork
          automatic int d = td_delay;
          automatic int g = gen;
          begin
            repeat (d) @(negedge clk);
            if (g == gen) begin
              bus.Tx_Done = 1'b1;
              @(negedge clk);
              bus.Tx_Done = 1'b0;
            end
          end
        join_none
      end
    end
  end

  initial begin : monitor
    xfer_t x;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.send_en) begin
          if (exp_send.size() == 0) fail_now("unexpected send_en", 32'(bus.grant_id));
          else begin
            x = exp_send.pop_front();
            check("grant_id at send_en", bus.grant_id, x.id);
            check("data_byte at send_en", bus.data_byte, x.b);
            check("busy at send_en", bus.busy, 1);
          end
        end
        if (bus.ack != 0) begin
          check("ack one-hot", $countones(bus.ack), 1);
          check("send_en with ack", bus.send_en, 0);
          if (exp_ack.size() == 0) fail_now("unexpected ack", 32'(bus.ack));
          else check("ack value", bus.ack, exp_ack.pop_front());
        end
        if (bus.timeout_err) begin
          check("ack with timeout_err", bus.ack, 0);
          if (exp_tout.size() == 0) fail_now("unexpected timeout_err", 32'(bus.grant_id));
          else check("timeout grant_id", bus.grant_id, exp_tout.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    bus.req        = '0;
    bus.data_in    = '0;
    bus.uart_state = 1'b0;
    tick(2);
    check_all_zero("reset");
    rst = 1'b0;
    tick(1);

    // Single request, Tx_Done 40 cycles after send_en
    td_delay = 40;
    bus.data_in[23:16] = 8'hA5;
    bus.req = 4'b0100;
    push_send(3'd2, 8'hA5);
    exp_ack.push_back(4'b0100);
    tick(1);
    check("t1 send_en after 1", bus.send_en, 0);
    check("t1 busy after grant", bus.busy, 1);
    tick(1);
    check("t1 send_en after 2", bus.send_en, 1);
    tick(40);
    check("t1 ack during Tx_Done", bus.ack, 0);
    tick(1);
    check("t1 ack", bus.ack, 4'b0100);
    check("t1 busy dropped", bus.busy, 0);
    bus.req = '0;
    tick(5);
    check("t1 data_byte held", bus.data_byte, 8'hA5);
    check("t1 grant_id held", bus.grant_id, 2);

    // All four requesting from reset: order 0,1,2,3,0
    rst = 1'b1;
    gen++;
    tick(2);
    rst = 1'b0;
    td_delay = 20;
    bus.data_in = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      push_send(3'(i % 4), 8'(8'h10 + i % 4));
      exp_ack.push_back(4'(1 << (i % 4)));
    end
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_send(200);
    bus.req = '0;
    wait_idle(200);
    tick(3);

    // uart_state busy holds off the grant
    bus.uart_state = 1'b1;
    bus.data_in[7:0] = 8'h3C;
    bus.req = 4'b0001;
    tick(10);
    check("t3 no grant while uart busy", bus.busy, 0);
    td_delay = 5;
    push_send(3'd0, 8'h3C);
    exp_ack.push_back(4'b0001);
    bus.uart_state = 1'b0;
    tick(1);
    check("t3 grant after release", bus.busy, 1);
    check("t3 send_en early", bus.send_en, 0);
    tick(1);
    check("t3 send_en", bus.send_en, 1);
    bus.req = '0;
    wait_idle(100);
    tick(3);

    // Watchdog: requester 0 never completes, requester 1 goes next
    td_delay = -1;
    bus.data_in[7:0]  = 8'h40;
    bus.data_in[15:8] = 8'h41;
    bus.req = 4'b0001;
    push_send(3'd0, 8'h40);
    exp_tout.push_back(3'd0);
    wait_send(50);
    tick(49);
    check("t4 timeout_err early", bus.timeout_err, 0);
    tick(1);
    check("t4 timeout_err", bus.timeout_err, 1);
    check("t4 no ack", bus.ack, 0);
    td_delay = 10;
    bus.req = 4'b0011;
    push_send(3'd1, 8'h41);
    exp_ack.push_back(4'b0010);
    wait_send(20);
    bus.req = '0;
    wait_idle(100);
    tick(3);

    // Tx_Done coincides with watchdog expiry
    td_delay = int'(TIMEOUT) - 1;
    bus.data_in[23:16] = 8'h5A;
    bus.req = 4'b0100;
    push_send(3'd2, 8'h5A);
    exp_ack.push_back(4'b0100);
    wait_send(50);
    bus.req = '0;
    tick(50);
    check("t5 ack wins", bus.ack, 4'b0100);
    check("t5 no timeout_err", bus.timeout_err, 0);
    tick(3);

    // Reset mid-WAIT, then requester 3 served afresh
    td_delay = 100;
    bus.data_in[31:24] = 8'h77;
    bus.req = 4'b1000;
    push_send(3'd3, 8'h77);
    wait_send(50);
    tick(10);
    rst = 1'b1;
    gen++;
    #1;
    check_all_zero("mid-wait reset");
    tick(2);
    td_delay = 5;
    push_send(3'd3, 8'h77);
    exp_ack.push_back(4'b1000);
    rst = 1'b0;
    tick(1);
    check("t6 send_en after 1", bus.send_en, 0);
    tick(1);
    check("t6 send_en after 2", bus.send_en, 1);
    bus.req = '0;
    wait_idle(100);
    tick(3);

    check("send queue drained", 32'(exp_send.size()), 0);
    check("ack queue drained", 32'(exp_ack.size()), 0);
    check("timeout queue drained", 32'(exp_tout.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
